fifo_v4: RTL and testbench
==========================

FIFO_V4 -- requirements
Module: fifo_v4

Interface
REQ-001 SHALL have parameter FALL_THROUGH, default 1'b0: when 1, data pushed into an empty FIFO is visible on data_o in the same cycle.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width when dtype is not overridden.
REQ-003 SHALL have parameter DEPTH, default 8: number of entries; legal range 1..2**16; DEPTH=0 is rejected by an elaboration-time assertion.
REQ-004 SHALL have parameter dtype, default logic [DATA_WIDTH-1:0]: payload type.
REQ-005 SHALL have derived parameters ADDR_DEPTH = (DEPTH>1) ? $clog2(DEPTH) : 1 and CNT_W = $clog2(DEPTH+1); neither is overridden by users.
REQ-006 SHALL have port clk_i, input, 1: clock; all state is updated on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port flush_i, input, 1: discard all contents.
REQ-009 SHALL have port testmode_i, input, 1: test mode; has no functional effect.
REQ-010 SHALL have port clr_stat_i, input, 1: clear the sticky error flags and the watermark.
REQ-011 SHALL have port alm_full_th_i, input, CNT_W: runtime almost-full threshold.
REQ-012 SHALL have port alm_empty_th_i, input, CNT_W: runtime almost-empty threshold.
REQ-013 SHALL have port data_i, input, dtype: push payload.
REQ-014 SHALL have port push_i, input, 1: push request.
REQ-015 SHALL have port pop_i, input, 1: pop request.
REQ-016 SHALL have port data_o, output, dtype: head entry.
REQ-017 SHALL have ports full_o, empty_o, alm_full_o and alm_empty_o, output, 1 each: status flags.
REQ-018 SHALL have port usage_o, output, CNT_W: number of stored entries, 0..DEPTH inclusive.
REQ-019 SHALL have port max_usage_o, output, CNT_W: highest usage_o value since the last reset or clear.
REQ-020 SHALL have ports overflow_o and underflow_o, output, 1 each: sticky error flags.

Function
REQ-021 SHALL store entries in a circular buffer with read and write pointers of ADDR_DEPTH bits and a separate CNT_W-bit counter.
- Pointers wrap from DEPTH-1 to 0, including when DEPTH is not a power of two.
REQ-022 SHALL accept a push iff push_i=1 and full_o=0; the entry is written at the write pointer on that edge.
REQ-023 SHALL accept a pop iff pop_i=1 and empty_o=0; the read pointer advances on that edge.
REQ-024 SHALL honour both accepted handshakes when a push and a pop occur in the same cycle, leaving usage unchanged.
- A push while full is rejected even when pop_i=1 in the same cycle.
REQ-025 SHALL derive full_o = (usage_o==DEPTH) and empty_o = (usage_o==0) from the registered counter when FALL_THROUGH=0.
REQ-026 SHALL behave as follows when FALL_THROUGH=1 and usage_o==0:
- empty_o = !push_i; data_o = data_i.
- push_i and pop_i both high: the payload bypasses storage; usage, pointers and the watermark are unchanged.
REQ-027 SHALL drive data_o from the entry at the read pointer in all other cases; data_o is don't-care while empty_o=1.
REQ-028 SHALL drive alm_full_o = (usage_o >= alm_full_th_i) and alm_empty_o = (usage_o <= alm_empty_th_i), combinationally from the registered usage.
- A threshold greater than DEPTH is legal: alm_full_o then never asserts, and alm_empty_o is then always asserted.
REQ-029 SHALL clear both pointers and usage_o when flush_i=1, and empty_o=1 from the next cycle.
- Flush takes priority over push and pop in the same cycle; the push is dropped and no error flag is set.
- Flush does not affect overflow_o, underflow_o or max_usage_o.
REQ-030 SHALL set overflow_o on the next edge when push_i=1 and full_o=0 is false, i.e. full_o=1, and flush_i=0; overflow_o holds until cleared.
REQ-031 SHALL set underflow_o on the next edge when pop_i=1 and empty_o=1 and flush_i=0; underflow_o holds until cleared.
REQ-032 SHALL update max_usage_o to the next usage value when that value exceeds the current max_usage_o.
REQ-033 SHALL clear overflow_o, underflow_o and max_usage_o when clr_stat_i=1.
- An error event in the same cycle as clr_stat_i wins, and its flag reads 1 after the edge.
- The watermark loads the next usage value instead of 0.
REQ-034 SHALL show usage_o incremented exactly one cycle after an accepted push, with no other added latency.

Reset
REQ-035 SHALL, on a rising edge with rst_ni=0, clear pointers, usage_o, max_usage_o, overflow_o and underflow_o; reset overrides all other inputs.
- Outputs after reset: empty_o=1, full_o=0, alm_empty_o=1, alm_full_o=(alm_full_th_i==0).
- Storage contents are not reset.
REQ-036 SHALL discard any in-flight operation when reset is asserted mid-operation; no partial state survives.

Verification
REQ-037 Test: DEPTH=5, 5 pushes of 1..5 -> full_o=1, usage_o=5; 6th push -> overflow_o=1 and content unchanged; 5 pops return 1,2,3,4,5.
REQ-038 Test: DEPTH=5, alternate push/pop 12 times -> pointer wrap with correct data order; simultaneous push+pop at usage 3 leaves usage_o at 3.
REQ-039 Test: FALL_THROUGH=1, empty FIFO, push_i=pop_i=1 with data 0xA5 -> data_o=0xA5 in the same cycle, usage_o remains 0, empty_o=0 during that cycle.
REQ-040 Test: alm_full_th_i=3, alm_empty_th_i=1, fill 0 to 4 -> alm_empty_o high at usage 0-1, alm_full_o high from usage 3; max_usage_o=4 after draining.
REQ-041 Test: usage 4, flush_i with push_i in the same cycle -> usage_o=0, empty_o=1 next cycle, overflow_o unchanged; then pop -> underflow_o=1; then clr_stat_i -> flags 0.
REQ-042 Test: rst_ni low for one edge at usage 3 with push_i=1 -> usage_o=0, empty_o=1, max_usage_o=0 after that edge.

Source files
------------

// File: rtl/fifo_v4.sv
// fifo_v4: circular-buffer FIFO with runtime almost-full/empty thresholds,
// optional fall-through on empty, usage watermark and sticky error flags.
module fifo_v4 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             testmode_i,
  input  logic             clr_stat_i,
  input  logic [CNT_W-1:0] alm_full_th_i,
  input  logic [CNT_W-1:0] alm_empty_th_i,
  input  dtype             data_i,
  input  logic             push_i,
  input  logic             pop_i,
  output dtype             data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             alm_full_o,
  output logic             alm_empty_o,
  output logic [CNT_W-1:0] usage_o,
  output logic [CNT_W-1:0] max_usage_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  if (DEPTH < 1 || DEPTH > 65536) begin : g_depth_check
    $error("fifo_v4: DEPTH must lie in 1..65536");
  end

  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_DEPTH-1:0] LAST_PTR  = ADDR_DEPTH'(DEPTH - 1);

  dtype                  mem [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr;
  logic [ADDR_DEPTH-1:0] wr_ptr;
  logic [CNT_W-1:0]      usage;
  logic [CNT_W-1:0]      usage_nxt;
  logic [CNT_W-1:0]      max_usage;
  logic                  overflow;
  logic                  underflow;
  logic                  is_zero;
  logic                  bypass;
  logic                  wr_en;
  logic                  rd_en;
  logic                  ovf_evt;
  logic                  unf_evt;

  // Test mode has no functional effect.
  logic unused_testmode;
  assign unused_testmode = testmode_i;

  // Status flags, handshake qualification and next usage value.
  always_comb begin
    is_zero = (usage == '0);
    full_o  = (usage == DEPTH_CNT);
    // With fall-through, an empty FIFO reports data as soon as a push arrives.
    empty_o = (FALL_THROUGH && is_zero) ? !push_i : is_zero;
    bypass  = FALL_THROUGH && is_zero && push_i && pop_i;
    wr_en   = push_i && !full_o && !bypass && !flush_i;
    rd_en   = pop_i && !empty_o && !bypass && !flush_i;
    ovf_evt = push_i && full_o && !flush_i;
    unf_evt = pop_i && empty_o && !flush_i;
    usage_nxt = usage;
    if (flush_i)
      usage_nxt = '0;
    else if (wr_en && !rd_en)
      usage_nxt = usage + CNT_W'(1);
    else if (rd_en && !wr_en)
      usage_nxt = usage - CNT_W'(1);
  end

  // Head-of-queue data, bypassing storage when fall-through and empty.
  always_comb begin
    data_o = (FALL_THROUGH && is_zero) ? data_i : mem[rd_ptr];
  end

  // Payload storage; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en)
      mem[wr_ptr] <= data_i;
  end

  // Pointers, occupancy counter, watermark and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      usage     <= '0;
      max_usage <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_en)
          wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ADDR_DEPTH'(1);
        if (rd_en)
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ADDR_DEPTH'(1);
      end
      usage <= usage_nxt;
      // A clear reloads the watermark with the incoming usage, not zero.
      if (clr_stat_i || usage_nxt > max_usage)
        max_usage <= usage_nxt;
      // Error events in the same cycle as a clear win.
      if (ovf_evt)
        overflow <= 1'b1;
      else if (clr_stat_i)
        overflow <= 1'b0;
      if (unf_evt)
        underflow <= 1'b1;
      else if (clr_stat_i)
        underflow <= 1'b0;
    end
  end

  // Output mapping and threshold comparisons on the registered usage.
  always_comb begin
    usage_o     = usage;
    max_usage_o = max_usage;
    overflow_o  = overflow;
    underflow_o = underflow;
    alm_full_o  = (usage >= alm_full_th_i);
    alm_empty_o = (usage <= alm_empty_th_i);
  end

endmodule

// File: tb/tb_fifo_v4.sv
// tb_fifo_v4: directed bench with a data scoreboard and a small reference
// model of occupancy, flags and watermark for a DEPTH=5 FIFO, plus a
// fall-through instance exercised with direct expectations.
module tb_fifo_v4;

  localparam int unsigned DW = 8;
  localparam int unsigned D  = 5;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush, clr;
  logic [CW-1:0] thf, the;
  logic [DW-1:0] din, dout;
  logic          push, pop;
  logic          full, empty, afull, aempty, ovf, unf;
  logic [CW-1:0] usage, maxu;

  logic [DW-1:0] ft_din, ft_dout;
  logic          ft_push, ft_pop;
  logic          ft_full, ft_empty, ft_afull, ft_aempty, ft_ovf, ft_unf;
  logic [CW-1:0] ft_usage, ft_maxu;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [DW-1:0] sb[$];
  int unsigned   m_usage;
  int unsigned   m_max;
  logic          m_ovf, m_unf;

  always #5 clk = ~clk;

  fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(1'b0),
    .clr_stat_i(clr), .alm_full_th_i(thf), .alm_empty_th_i(the),
    .data_i(din), .push_i(push), .pop_i(pop), .data_o(dout),
    .full_o(full), .empty_o(empty), .alm_full_o(afull), .alm_empty_o(aempty),
    .usage_o(usage), .max_usage_o(maxu), .overflow_o(ovf), .underflow_o(unf)
  );

  fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(DW), .DEPTH(D)) dut_ft (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .testmode_i(1'b1),
    .clr_stat_i(1'b0), .alm_full_th_i(thf), .alm_empty_th_i(the),
    .data_i(ft_din), .push_i(ft_push), .pop_i(ft_pop), .data_o(ft_dout),
    .full_o(ft_full), .empty_o(ft_empty), .alm_full_o(ft_afull),
    .alm_empty_o(ft_aempty), .usage_o(ft_usage), .max_usage_o(ft_maxu),
    .overflow_o(ft_ovf), .underflow_o(ft_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("usage", 32'(usage), m_usage);
    chk("full", 32'(full), 32'(m_usage == D));
    chk("empty", 32'(empty), 32'(m_usage == 0));
    chk("alm_full", 32'(afull), 32'(m_usage >= 32'(thf)));
    chk("alm_empty", 32'(aempty), 32'(m_usage <= 32'(the)));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(unf), 32'(m_unf));
    chk("max_usage", 32'(maxu), m_max);
  endtask

  // One clock of stimulus on the main instance, with model update and checks.
  task automatic step(input logic p, input logic q, input logic [DW-1:0] d,
                      input logic fl = 1'b0, input logic cl = 1'b0);
    logic pa, qa, oe, ue;
    @(negedge clk);
    push = p; pop = q; din = d; flush = fl; clr = cl;
    #1;
    pa = p && (m_usage != D) && !fl;
    qa = q && (m_usage != 0) && !fl;
    oe = p && (m_usage == D) && !fl;
    ue = q && (m_usage == 0) && !fl;
    if (qa) chk("pop_data", 32'(dout), 32'(sb[0]));
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      if (qa) void'(sb.pop_front());
      if (pa) sb.push_back(d);
    end
    m_usage = sb.size();
    m_ovf = oe ? 1'b1 : (cl ? 1'b0 : m_ovf);
    m_unf = ue ? 1'b1 : (cl ? 1'b0 : m_unf);
    if (cl || m_usage > m_max) m_max = m_usage;
    #1;
    check_state();
  endtask

  task automatic do_reset(input logic p);
    @(negedge clk);
    rst_n = 1'b0; push = p; pop = 1'b0; flush = 1'b0; clr = 1'b0; din = 8'hEE;
    @(posedge clk);
    sb.delete();
    m_usage = 0; m_max = 0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1; push = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
    ft_push = 1'b0; ft_pop = 1'b0; ft_din = '0;
    thf = 3'd0; the = 3'd1;
    m_usage = 0; m_max = 0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset state; zero almost-full threshold asserts alm_full when empty.
    do_reset(1'b0);
    thf = 3'd3;

    // Fill 0..4 watching thresholds, then drain; watermark stays 4.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
    chk("max_after_drain", 32'(maxu), 32'd4);

    // Fill to full, overflow push, drain in order 1..5.
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'h66);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Alternating push/pop wraps the pointers; then push+pop at usage 3.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 8'(8'h20 + i));
      step(1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'h50 + i));
    step(1'b1, 1'b0, 8'h60);

    // Flush with push at usage 4, underflow on empty, then clear.
    step(1'b1, 1'b0, 8'h70, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    // Error in the same cycle as a clear wins.
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Push while full is rejected even with a simultaneous pop.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    step(1'b1, 1'b1, 8'h99);
    step(1'b1, 1'b0, 8'h9A);

    // Thresholds beyond DEPTH.
    thf = 3'd7; the = 3'd7;
    step(1'b0, 1'b0, 8'h00);
    thf = 3'd3; the = 3'd1;

    // Reset at usage 3 with a push pending.
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    do_reset(1'b1);
    step(1'b1, 1'b0, 8'hC3);
    step(1'b0, 1'b1, 8'h00);

    // Fall-through instance: bypass on empty with push+pop.
    @(negedge clk);
    #1;
    chk("ft_idle_empty", 32'(ft_empty), 32'd1);
    @(negedge clk);
    ft_push = 1'b1; ft_pop = 1'b1; ft_din = 8'hA5;
    #1;
    chk("ft_bypass_data", 32'(ft_dout), 32'hA5);
    chk("ft_bypass_empty", 32'(ft_empty), 32'd0);
    @(posedge clk); #1;
    chk("ft_bypass_usage", 32'(ft_usage), 32'd0);
    chk("ft_bypass_max", 32'(ft_maxu), 32'd0);
    chk("ft_bypass_unf", 32'(ft_unf), 32'd0);
    @(negedge clk);
    ft_pop = 1'b0; ft_din = 8'h3C;
    #1;
    chk("ft_push_data", 32'(ft_dout), 32'h3C);
    @(posedge clk); #1;
    chk("ft_usage1", 32'(ft_usage), 32'd1);
    chk("ft_stored_data", 32'(ft_dout), 32'h3C);
    @(negedge clk);
    ft_din = 8'h77;
    #1;
    chk("ft_head_kept", 32'(ft_dout), 32'h3C);
    @(posedge clk); #1;
    chk("ft_usage2", 32'(ft_usage), 32'd2);
    chk("ft_max2", 32'(ft_maxu), 32'd2);
    @(negedge clk);
    ft_push = 1'b0; ft_pop = 1'b1;
    @(posedge clk); #1;
    chk("ft_pop1_data", 32'(ft_dout), 32'h77);
    @(posedge clk); #1;
    chk("ft_drained", 32'(ft_usage), 32'd0);
    chk("ft_drained_empty", 32'(ft_empty), 32'd1);
    chk("ft_no_unf", 32'(ft_unf), 32'd0);
    @(posedge clk); #1;
    chk("ft_underflow", 32'(ft_unf), 32'd1);
    @(negedge clk);
    ft_pop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
